// File: rtl/sevenseg_wb_regs_if.sv
// sevenseg_wb_regs_if: Wishbone classic slave bundle for the seven-segment register block.
interface sevenseg_wb_regs_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );
    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/sevenseg_wb_regs.sv
// sevenseg_wb_regs: Wishbone register block driving a multiplexed hex seven-segment display.
module sevenseg_wb_regs #(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          NUM_DIGITS  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd999
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_ni,
    sevenseg_wb_regs_if.slave     wb,
    output logic [7:0]            seg_o,
    output logic [NUM_DIGITS-1:0] an_o
);
    localparam logic [31:0] CTRL_MASK = 32'h3 | (32'((64'd1 << NUM_DIGITS) - 64'd1) << 8);
    localparam logic [31:0] DIG_MASK  = 32'((64'd1 << (4 * NUM_DIGITS)) - 64'd1);
    localparam logic [2:0]  LAST      = 3'(NUM_DIGITS - 1);
    localparam logic [6:0]  HEX7 [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [31:0] ctrl, digits, rdata, wmask, ctrl_new, dig_new;
    logic [15:0] div, cnt;
    logic [2:0]  idx;
    logic        flag, hit, xfer, wr, wr_ctrl, wr_dig, wr_div, tick, blank_out;
    logic [7:0]  onehot, dp;
    logic [3:0]  nib;
    always_comb begin
        hit       = wb.wbs_cyc_i & wb.wbs_stb_i & (wb.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
        xfer      = hit & ~wb.wbs_ack_o;
        wr        = xfer & wb.wbs_we_i;
        wr_ctrl   = wr & (wb.wbs_adr_i[3:2] == 2'd0);
        wr_dig    = wr & (wb.wbs_adr_i[3:2] == 2'd1);
        wr_div    = wr & (wb.wbs_adr_i[3:2] == 2'd2);
        wmask     = {{8{wb.wbs_sel_i[3]}}, {8{wb.wbs_sel_i[2]}}, {8{wb.wbs_sel_i[1]}}, {8{wb.wbs_sel_i[0]}}};
        ctrl_new  = ((ctrl & ~wmask) | (wb.wbs_dat_i & wmask)) & CTRL_MASK;
        dig_new   = ((digits & ~wmask) | (wb.wbs_dat_i & wmask)) & DIG_MASK;
        rdata     = wb.wbs_adr_i[3:2] == 2'd0 ? ctrl :
                    wb.wbs_adr_i[3:2] == 2'd1 ? digits :
                    wb.wbs_adr_i[3:2] == 2'd2 ? {16'd0, div} : {cnt, 13'd0, idx};
        tick      = ctrl[0] & (cnt == div);
        blank_out = ~ctrl[0] | ctrl[1] | flag;
        onehot    = 8'd1 << idx;
        dp        = ctrl[15:8];
        nib       = digits[{idx, 2'b00} +: 4];
    end
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            ctrl          <= '0;
            digits        <= '0;
            div           <= DEFAULT_DIV;
            cnt           <= '0;
            idx           <= '0;
            flag          <= 1'b0;
            wb.wbs_ack_o  <= 1'b0;
            wb.wbs_dat_o  <= '0;
            seg_o         <= '0;
            an_o          <= '1;
        end else begin
            wb.wbs_ack_o <= xfer;
            wb.wbs_dat_o <= xfer ? rdata : '0;
            if (wr_ctrl) ctrl <= ctrl_new;
            if (wr_dig) digits <= dig_new;
            if (wr_div) div <= (div & ~wmask[15:0]) | (wb.wbs_dat_i[15:0] & wmask[15:0]);
            // A divider write restarts the digit period without moving the index
            cnt  <= (wr_div | tick) ? 16'd0 : ctrl[0] ? cnt + 16'd1 : cnt;
            flag <= tick & ~wr_div;
            if (tick & ~wr_div) idx <= idx == LAST ? 3'd0 : idx + 3'd1;
            an_o  <= blank_out ? '1 : ~onehot[NUM_DIGITS-1:0];
            seg_o <= blank_out ? 8'd0 : {dp[idx], HEX7[nib]};
        end
    end
endmodule

// File: tb/tb_sevenseg_wb_regs.sv
// tb_sevenseg_wb_regs: directed checks of bus access, scan sequencing and reset behaviour.
module tb_sevenseg_wb_regs;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] A_CTRL = BASE, A_DIG = BASE + 32'h4, A_DIV = BASE + 32'h8, A_STAT = BASE + 32'hC;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [7:0] seg;
    logic [3:0] an;
    int vectors = 0, miscompares = 0;
    logic [7:0] seg_tab [4] = '{8'h7C, 8'h77, 8'h5B, 8'h06};
    logic [3:0] an_tab [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    always #5 clk = ~clk;
    sevenseg_wb_regs_if bus();
    sevenseg_wb_regs dut (.wb_clk_i(clk), .wb_rst_ni(rst_n), .wb(bus), .seg_o(seg), .an_o(an));
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, output logic [31:0] rd, output int lat);
        @(negedge clk);
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
        bus.wbs_adr_i = adr; bus.wbs_dat_i = dat; bus.wbs_sel_i = sel;
        lat = 0; rd = '0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (bus.wbs_ack_o) begin lat = i; rd = bus.wbs_dat_o; break; end
        end
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    endtask
    task automatic wr(input string tag, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] rd; int lat;
        xfer(1'b1, adr, dat, sel, rd, lat);
        check({tag, "_ack_lat"}, lat, 1);
    endtask
    task automatic rd_chk(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] rd; int lat;
        xfer(1'b0, adr, 32'd0, 4'hF, rd, lat);
        check({tag, "_ack_lat"}, lat, 1);
        check(tag, rd, exp);
    endtask
    initial begin
        logic [31:0] rd, s1, s2;
        int lat, j, d, seen_b;
        bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
        bus.wbs_sel_i = 0; bus.wbs_dat_i = 0; bus.wbs_adr_i = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check("rst_ack", bus.wbs_ack_o, 0);
        check("rst_an", an, 4'hF);
        check("rst_seg", seg, 0);
        check("rst_dat", bus.wbs_dat_o, 0);
        rd_chk("rst_div", A_DIV, 32'd999);
        rd_chk("rst_dig", A_DIG, 32'd0);
        rd_chk("rst_ctrl", A_CTRL, 32'd0);
        wr("dig_w", A_DIG, 32'h0000_1234, 4'hF);
        rd_chk("dig_rb", A_DIG, 32'h0000_1234);
        wr("dig_b0", A_DIG, 32'h0000_00AB, 4'b0001);
        rd_chk("dig_sel", A_DIG, 32'h0000_12AB);
        wr("dig_hi", A_DIG, 32'hFFFF_0000, 4'b1100);
        rd_chk("dig_mask", A_DIG, 32'h0000_12AB);
        wr("stat_w", A_STAT, 32'hFFFF_FFFF, 4'hF);
        rd_chk("stat_ro", A_STAT, 32'd0);
        wr("div3", A_DIV, 32'd3, 4'hF);
        rd_chk("div_rb", A_DIV, 32'd3);
        wr("en", A_CTRL, 32'd1, 4'hF);
        // first digit shows 4 cycles after enable, then 1 blank + 3 lit per digit
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            j = k - 5;
            d = k <= 4 ? 0 : (j % 4 == 0) ? -1 : (1 + j / 4) % 4;
            check($sformatf("scan_an%0d", k), an, d < 0 ? 4'hF : an_tab[d]);
            check($sformatf("scan_seg%0d", k), seg, d < 0 ? 8'h00 : seg_tab[d]);
        end
        wr("ctrl_all", A_CTRL, 32'hFFFF_FFFF, 4'hF);
        rd_chk("ctrl_mask", A_CTRL, 32'h0000_0F03);
        @(negedge clk);
        check("blank_an", an, 4'hF);
        wr("dp", A_CTRL, 32'h0000_0401, 4'hF);
        seen_b = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (an == 4'hB) seen_b++;
            check($sformatf("dp%0d", k), seg[7], an == 4'hB);
        end
        check("dp_seen", seen_b >= 3, 1);
        wr("div0", A_DIV, 32'd0, 4'hF);
        xfer(1'b0, A_STAT, 32'd0, 4'hF, s1, lat);
        xfer(1'b0, A_STAT, 32'd0, 4'hF, s2, lat);
        check("div0_idx", s2[2:0], (s1[2:0] + 3'd2) % 3'd4);
        check("div0_cnt", s2[31:16], 0);
        check("div0_an", an, 4'hF);
        check("div0_seg", seg, 0);
        xfer(1'b0, BASE + 32'h10, 32'd0, 4'hF, rd, lat);
        check("unmapped_ack", lat, 0);
        @(negedge clk);
        bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 0; bus.wbs_adr_i = A_DIV;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("burst_ack%0d", k), bus.wbs_ack_o, k % 2 == 0);
        end
        bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0;
        @(negedge clk);
        bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 1;
        bus.wbs_adr_i = A_DIG; bus.wbs_dat_i = 32'h0000_0077; bus.wbs_sel_i = 4'hF;
        @(negedge clk);
        check("pre_rst_ack", bus.wbs_ack_o, 1);
        rst_n = 1'b0; bus.wbs_dat_i = 32'h0000_5555;
        @(negedge clk);
        check("rst_mid_ack", bus.wbs_ack_o, 0);
        @(negedge clk);
        check("rst_hold_ack", bus.wbs_ack_o, 0);
        rst_n = 1'b1; bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
        rd_chk("rst_mid_dig", A_DIG, 32'd0);
        rd_chk("rst_mid_div", A_DIV, 32'd999);
        check("rst_mid_an", an, 4'hF);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
